// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: DEPTH x DATA_W instruction store with one program-load write
// port and one fetch read port. The fetched word is registered behind a
// ready/valid handshake; when the data side owns the bus the output is filled
// with a NOP bubble instead of a real fetch.
// Build option: define IMEM_PARITY_EN to keep one even-parity bit per word,
// computed at load and checked on every fetch.
// DEPTH must not exceed 2**ADDR_W.
module instr_fetch_mem #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 6,
   parameter int                DEPTH    = 40,
   parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       pc,
   input  logic              fetch_req,
   output logic              fetch_ready,
   input  logic              mem_conflict,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              instr_err,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [15:0]       stall_cnt
);

`ifdef IMEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VALID  = 2'd1,
      BUBBLE = 2'd2
   } state_t;

   logic [MEM_W-1:0]  mem [DEPTH];

   logic              pc_in_range;
   logic              load_in_range;
   logic              bypass_hit;
   logic              rd_par_err;
   logic [ADDR_W-1:0] rd_idx;
   logic [MEM_W-1:0]  rd_word;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_err;
   logic              out_free;
   logic              take;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] instr_nxt;
   logic              instr_err_nxt;

   // Saturating increment so the stall counter sticks at all-ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Stored word format: data, plus the even-parity bit on top when enabled.
   function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef IMEM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   // True when a stored word no longer matches its parity bit.
   function automatic logic word_corrupt(input logic [MEM_W-1:0] w);
`ifdef IMEM_PARITY_EN
      return (^w[DATA_W-1:0]) != w[DATA_W];
`else
      return (w[0] & 1'b0);
`endif
   endfunction

   // Program-load write port; addresses past the implemented depth are dropped.
   always_ff @(posedge clk) begin
      if (load_we && load_in_range) begin
         mem[load_addr] <= pack_word(load_data);
      end
   end

   // Fetch read path: range check, write-first bypass, parity check.
   always_comb begin
      pc_in_range   = (pc[15:ADDR_W] == '0) && ({1'b0, pc[ADDR_W-1:0]} < DEPTH_LIM);
      load_in_range = ({1'b0, load_addr} < DEPTH_LIM);
      rd_idx        = pc_in_range ? pc[ADDR_W-1:0] : '0;
      rd_word       = mem[rd_idx];
      bypass_hit    = load_we && load_in_range && (load_addr == pc[ADDR_W-1:0]);
      rd_par_err    = word_corrupt(rd_word);
      fetch_data    = NOP_WORD;
      fetch_err     = 1'b1;
      if (pc_in_range) begin
         if (bypass_hit) begin
            fetch_data = load_data;
            fetch_err  = 1'b0;
         end else if (!rd_par_err) begin
            fetch_data = rd_word[DATA_W-1:0];
            fetch_err  = 1'b0;
         end
      end
   end

   // Handshake and next-state / next-output decode.
   always_comb begin
      out_free      = (state == IDLE) || instr_ready;
      fetch_ready   = !mem_conflict && out_free;
      take          = fetch_req && fetch_ready;
      state_nxt     = state;
      instr_nxt     = instr;
      instr_err_nxt = instr_err;
      if (take) begin
         state_nxt     = VALID;
         instr_nxt     = fetch_data;
         instr_err_nxt = fetch_err;
      end else if (mem_conflict && out_free) begin
         // Bus is taken by the data side: present a clean NOP bubble.
         state_nxt     = BUBBLE;
         instr_nxt     = NOP_WORD;
         instr_err_nxt = 1'b0;
      end else if ((state != IDLE) && instr_ready) begin
         state_nxt     = IDLE;
         instr_err_nxt = 1'b0;
      end
   end

   assign instr_valid = (state != IDLE);

   // State and output register; reset discards any pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         instr     <= NOP_WORD;
         instr_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         instr     <= instr_nxt;
         instr_err <= instr_err_nxt;
      end
   end

   // Count every edge the data side holds the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
      end else if (mem_conflict) begin
         stall_cnt <= sat_inc16(stall_cnt);
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: table-driven scenarios with a result scoreboard.
module tb_instr_fetch_mem;

   localparam int          DEPTH = 40;
   localparam logic [15:0] NOP   = 16'h0800;

   typedef struct {
      bit          req;
      logic [15:0] pc;
      bit          rdy;
      bit          mc;
      bit          we;
      logic [5:0]  la;
      logic [15:0] ld;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc = '0;
   logic        fetch_req = 1'b0;
   logic        fetch_ready;
   logic        mem_conflict = 1'b0;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        instr_err;
   logic        load_we = 1'b0;
   logic [5:0]  load_addr = '0;
   logic [15:0] load_data = '0;
   logic [15:0] stall_cnt;

   int          total = 0;
   int          bad = 0;

   logic [16:0] sb[$];
   logic [16:0] junk;
   bit          m_valid = 1'b0;
   bit          m_fr = 1'b0;
   logic [15:0] m_stall = '0;
   logic [15:0] m_mem [DEPTH];
   bit          par_bad [DEPTH];

   always #5 clk = ~clk;

   instr_fetch_mem #(
      .DATA_W  (16),
      .ADDR_W  (6),
      .DEPTH   (DEPTH),
      .NOP_WORD(NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .fetch_req   (fetch_req),
      .fetch_ready (fetch_ready),
      .mem_conflict(mem_conflict),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_err   (instr_err),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .stall_cnt   (stall_cnt)
   );

   function automatic stim_t mk(input bit req, input logic [15:0] p, input bit rdy, input bit mc);
      stim_t s;
      s.req = req; s.pc = p; s.rdy = rdy; s.mc = mc;
      s.we = 1'b0; s.la = '0; s.ld = '0;
      return s;
   endfunction

   function automatic stim_t mkl(input logic [5:0] la, input logic [15:0] ld);
      stim_t s;
      s = mk(1'b0, 16'd0, 1'b0, 1'b0);
      s.we = 1'b1; s.la = la; s.ld = ld;
      return s;
   endfunction

   // Expected {err, instr} for a fetch accepted with stimulus s.
   function automatic logic [16:0] exp_fetch(input stim_t s);
      if (s.pc[15:6] != 10'd0 || int'(s.pc[5:0]) >= DEPTH) return {1'b1, NOP};
      if (s.we && s.la == s.pc[5:0]) return {1'b0, s.ld};
      if (par_bad[s.pc[5:0]]) return {1'b1, NOP};
      return {1'b0, m_mem[s.pc[5:0]]};
   endfunction

   // Drive one cycle of stimulus half a period before the active edge.
   task automatic apply(input stim_t s);
      @(negedge clk);
      fetch_req = s.req; pc = s.pc; instr_ready = s.rdy; mem_conflict = s.mc;
      load_we = s.we; load_addr = s.la; load_data = s.ld;
      #1;
      m_fr = !s.mc && (!m_valid || s.rdy);
   endtask

   // Advance the reference model across the coming active edge.
   task automatic retire(input stim_t s);
      bit free;
      free = !m_valid || s.rdy;
      if (m_valid && s.rdy) begin
         junk = sb.pop_front();
         m_valid = 1'b0;
      end
      if (s.req && m_fr) begin
         sb.push_back(exp_fetch(s));
         m_valid = 1'b1;
      end else if (s.mc && free) begin
         sb.push_back({1'b0, NOP});
         m_valid = 1'b1;
      end
      if (s.mc && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (s.we && int'(s.la) < DEPTH) begin
         m_mem[s.la] = s.ld;
         par_bad[s.la] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_conflict = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset.instr_valid got=%b want=0", instr_valid); end
      total++;
      if (instr !== NOP) begin bad++; $display("FAIL reset.instr got=%h want=%h", instr, NOP); end
      total++;
      if (instr_err !== 1'b0) begin bad++; $display("FAIL reset.instr_err got=%b want=0", instr_err); end
      total++;
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset.stall_cnt got=%0d want=0", stall_cnt); end
      total++;
      if (fetch_ready !== 1'b0) begin bad++; $display("FAIL reset.fetch_ready_conflict got=%b want=0", fetch_ready); end
      mem_conflict = 1'b0;
      #1;
      total++;
      if (fetch_ready !== 1'b1) begin bad++; $display("FAIL reset.fetch_ready got=%b want=1", fetch_ready); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_program();
      stim_t t[$];
      t = {mkl(6'd0, 16'h4815), mkl(6'd1, 16'h490D), mkl(6'd2, 16'h1234),
           mkl(6'd3, 16'h5678), mkl(6'd4, 16'h9ABC), mkl(6'd5, 16'h1111),
           mkl(6'd13, 16'h2222)};
      foreach (t[i]) begin
         apply(t[i]);
         retire(t[i]);
      end
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      t = {mk(1, 16'd0, 1, 0), mk(1, 16'd1, 1, 0), mk(0, 16'd0, 1, 0), mk(0, 16'd0, 0, 0)};
      foreach (t[i]) begin
         apply(t[i]);
         total++;
         if (fetch_ready !== m_fr) begin bad++; $display("FAIL b2b.fetch_ready[%0d] got=%b want=%b", i, fetch_ready, m_fr); end
         total++;
         if (instr_valid !== m_valid) begin bad++; $display("FAIL b2b.instr_valid[%0d] got=%b want=%b", i, instr_valid, m_valid); end
         if (m_valid) begin
            total++;
            if ({instr_err, instr} !== sb[0]) begin bad++; $display("FAIL b2b.instr[%0d] got=%b/%h want=%b/%h", i, instr_err, instr, sb[0][16], sb[0][15:0]); end
         end
         retire(t[i]);
      end
   endtask

   task automatic test_hold_conflict();
      stim_t t[$];
      t = {mk(1, 16'd2, 0, 0), mk(1, 16'd3, 0, 0), mk(1, 16'd3, 0, 1), mk(1, 16'd3, 0, 0),
           mk(0, 16'd0, 1, 0), mk(0, 16'd0, 0, 0)};
      foreach (t[i]) begin
         apply(t[i]);
         total++;
         if (fetch_ready !== m_fr) begin bad++; $display("FAIL hold.fetch_ready[%0d] got=%b want=%b", i, fetch_ready, m_fr); end
         total++;
         if (instr_valid !== m_valid) begin bad++; $display("FAIL hold.instr_valid[%0d] got=%b want=%b", i, instr_valid, m_valid); end
         if (m_valid) begin
            total++;
            if ({instr_err, instr} !== sb[0]) begin bad++; $display("FAIL hold.instr[%0d] got=%b/%h want=%b/%h", i, instr_err, instr, sb[0][16], sb[0][15:0]); end
         end
         total++;
         if (stall_cnt !== m_stall) begin bad++; $display("FAIL hold.stall_cnt[%0d] got=%0d want=%0d", i, stall_cnt, m_stall); end
         retire(t[i]);
      end
   endtask

   task automatic test_bubble();
      stim_t t[$];
      t = {mk(0, 16'd0, 0, 1), mk(0, 16'd0, 0, 1), mk(0, 16'd0, 0, 1), mk(0, 16'd0, 0, 1),
           mk(1, 16'd0, 1, 1), mk(1, 16'd4, 1, 0), mk(0, 16'd0, 1, 0), mk(0, 16'd0, 1, 1),
           mk(0, 16'd0, 1, 0), mk(0, 16'd0, 0, 0)};
      foreach (t[i]) begin
         apply(t[i]);
         total++;
         if (fetch_ready !== m_fr) begin bad++; $display("FAIL bubble.fetch_ready[%0d] got=%b want=%b", i, fetch_ready, m_fr); end
         total++;
         if (instr_valid !== m_valid) begin bad++; $display("FAIL bubble.instr_valid[%0d] got=%b want=%b", i, instr_valid, m_valid); end
         if (m_valid) begin
            total++;
            if ({instr_err, instr} !== sb[0]) begin bad++; $display("FAIL bubble.instr[%0d] got=%b/%h want=%b/%h", i, instr_err, instr, sb[0][16], sb[0][15:0]); end
         end
         total++;
         if (stall_cnt !== m_stall) begin bad++; $display("FAIL bubble.stall_cnt[%0d] got=%0d want=%0d", i, stall_cnt, m_stall); end
         retire(t[i]);
      end
   endtask

   task automatic test_range();
      stim_t t[$];
      stim_t ld45;
      ld45 = mk(1, 16'd5, 1, 0);
      ld45.we = 1'b1; ld45.la = 6'd45; ld45.ld = 16'hFFFF;
      t = {mk(1, 16'd40, 1, 0), mk(1, 16'h0040, 1, 0), mk(1, 16'hFFFF, 1, 0), mk(1, 16'd39 + 16'd1, 1, 0),
           ld45, mk(1, 16'd5, 1, 0), mk(1, 16'd13, 1, 0), mk(0, 16'd0, 1, 0), mk(0, 16'd0, 0, 0)};
      foreach (t[i]) begin
         apply(t[i]);
         total++;
         if (fetch_ready !== m_fr) begin bad++; $display("FAIL range.fetch_ready[%0d] got=%b want=%b", i, fetch_ready, m_fr); end
         total++;
         if (instr_valid !== m_valid) begin bad++; $display("FAIL range.instr_valid[%0d] got=%b want=%b", i, instr_valid, m_valid); end
         if (m_valid) begin
            total++;
            if ({instr_err, instr} !== sb[0]) begin bad++; $display("FAIL range.instr[%0d] got=%b/%h want=%b/%h", i, instr_err, instr, sb[0][16], sb[0][15:0]); end
         end
         retire(t[i]);
      end
   endtask

   task automatic test_bypass_reset();
      stim_t t[$];
      stim_t byp;
      byp = mk(1, 16'd5, 1, 0);
      byp.we = 1'b1; byp.la = 6'd5; byp.ld = 16'hA5A5;
      t = {byp, mk(1, 16'd5, 1, 0), mk(1, 16'd0, 0, 0), mk(1, 16'd0, 0, 0)};
      foreach (t[i]) begin
         apply(t[i]);
         total++;
         if (instr_valid !== m_valid) begin bad++; $display("FAIL bypass.instr_valid[%0d] got=%b want=%b", i, instr_valid, m_valid); end
         if (m_valid) begin
            total++;
            if ({instr_err, instr} !== sb[0]) begin bad++; $display("FAIL bypass.instr[%0d] got=%b/%h want=%b/%h", i, instr_err, instr, sb[0][16], sb[0][15:0]); end
         end
         retire(t[i]);
      end
      // Assert reset between edges while a real word is held.
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (instr_valid !== 1'b0) begin bad++; $display("FAIL midrst.instr_valid got=%b want=0", instr_valid); end
      total++;
      if (instr !== NOP) begin bad++; $display("FAIL midrst.instr got=%h want=%h", instr, NOP); end
      total++;
      if (stall_cnt !== 16'd0) begin bad++; $display("FAIL midrst.stall_cnt got=%0d want=0", stall_cnt); end
      sb.delete();
      m_valid = 1'b0;
      m_stall = '0;
      @(negedge clk);
      rst = 1'b0;
      t = {mk(1, 16'd1, 1, 0), mk(0, 16'd0, 1, 0), mk(0, 16'd0, 0, 0)};
      foreach (t[i]) begin
         apply(t[i]);
         total++;
         if (fetch_ready !== m_fr) begin bad++; $display("FAIL postrst.fetch_ready[%0d] got=%b want=%b", i, fetch_ready, m_fr); end
         if (m_valid) begin
            total++;
            if ({instr_err, instr} !== sb[0]) begin bad++; $display("FAIL postrst.instr[%0d] got=%b/%h want=%b/%h", i, instr_err, instr, sb[0][16], sb[0][15:0]); end
         end
         retire(t[i]);
      end
   endtask

`ifdef IMEM_PARITY_EN
   task automatic test_parity();
      stim_t t[$];
      @(negedge clk);
      dut.mem[3][16] = ~dut.mem[3][16];
      par_bad[3] = 1'b1;
      t = {mk(1, 16'd3, 1, 0), mk(1, 16'd2, 1, 0), mk(0, 16'd0, 1, 0), mk(0, 16'd0, 0, 0)};
      foreach (t[i]) begin
         apply(t[i]);
         total++;
         if (instr_valid !== m_valid) begin bad++; $display("FAIL parity.instr_valid[%0d] got=%b want=%b", i, instr_valid, m_valid); end
         if (m_valid) begin
            total++;
            if ({instr_err, instr} !== sb[0]) begin bad++; $display("FAIL parity.instr[%0d] got=%b/%h want=%b/%h", i, instr_err, instr, sb[0][16], sb[0][15:0]); end
         end
         retire(t[i]);
      end
   endtask
`endif

   initial begin
      foreach (par_bad[i]) par_bad[i] = 1'b0;
      test_reset();
      load_program();
      test_back_to_back();
      test_hold_conflict();
      test_bubble();
      test_range();
      test_bypass_reset();
`ifdef IMEM_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
